data_sync_reader: RTL and testbench



---
 rtl/data_sync_reader.sv | 118 +++++++++++
 tb/tb_data_sync_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_reader.sv
// Consumer for the output side of the DataSync handshake: captures each
// synchronized word once, pulses sync_retrieved, and buffers words in a FWFT FIFO.
module data_sync_reader #(
  parameter int unsigned W       = 4,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [W-1:0]             sync_data,
  input  logic                     sync_valid,
  output logic                     sync_retrieved,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ack_error
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = 16;

  localparam logic [1:0] WAIT_VALID = 2'd0;
  localparam logic [1:0] ACK        = 2'd1;
  localparam logic [1:0] WAIT_DROP  = 2'd2;

  logic [1:0]    state, state_next;
  logic          retrieved_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          err_next;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level_next;
  logic          not_full;
  logic          push;
  logic          pop;

  // Fullness is judged on the registered level, so a same-cycle pop never frees a slot early.
  assign not_full = (level != LW'(DEPTH));
  assign push     = (state == WAIT_VALID) && sync_valid && not_full;
  assign pop      = out_valid && out_ready;
  assign out_data = mem[rd_ptr];

  // Handshake next-state and registered-output logic
  always_comb begin
    state_next     = state;
    retrieved_next = 1'b0;
    cnt_next       = cnt;
    err_next       = ack_error;
    case (state)
      WAIT_VALID: begin
        if (push) begin
          state_next     = ACK;
          retrieved_next = 1'b1;
        end
      end
      ACK: begin
        state_next = WAIT_DROP;
        cnt_next   = '0;
      end
      WAIT_DROP: begin
        if (!sync_valid) begin
          state_next = WAIT_VALID;
        end else if (cnt == CW'(TIMEOUT)) begin
          err_next = 1'b1;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: state_next = WAIT_VALID;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= WAIT_VALID;
      sync_retrieved <= 1'b0;
      cnt            <= '0;
      ack_error      <= 1'b0;
    end else begin
      state          <= state_next;
      sync_retrieved <= retrieved_next;
      cnt            <= cnt_next;
      ack_error      <= err_next;
    end
  end

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level     <= level_next;
      out_valid <= (level_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sync_data;
  end

endmodule

// File: tb/tb_data_sync_reader.sv
// Scoreboard bench for data_sync_reader: a DataSync-like producer feeds words,
// a negedge monitor pops expected words whenever the DUT hands one downstream.
module tb_data_sync_reader;

  localparam int unsigned W       = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned LW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  sync_data;
  logic          sync_valid;
  logic          sync_retrieved;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [LW-1:0] level;
  logic          ack_error;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int words  = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_w;
  logic p5_done;
  logic rnd_stop;

  data_sync_reader #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sync_data      (sync_data),
    .sync_valid     (sync_valid),
    .sync_retrieved (sync_retrieved),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .level          (level),
    .ack_error      (ack_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count retrieve pulses and score every word consumed downstream
  always @(negedge clk) begin
    if (reset_n) begin
      if (sync_retrieved) pulses++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got %0d expected nothing (scoreboard empty) at %0t", out_data, $time);
        end else begin
          exp_w = sb.pop_front();
          check("out_data", 32'(out_data), 32'(exp_w));
        end
      end
    end
  end

  // DataSync-like producer: hold valid until retrieved, drop it one cycle later
  task automatic present(input logic [W-1:0] d, input int limit);
    bit got = 0;
    sync_data  = d;
    sync_valid = 1'b1;
    sb.push_back(d);
    words++;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sync_retrieved) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL present_timeout: word %0d got no retrieve within %0d cycles", d, limit);
    end
    @(posedge clk); #1;
    sync_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int limit);
    out_ready = 1'b1;
    for (int i = 0; i < limit && level != '0; i++) begin
      @(posedge clk); #1;
    end
    check("drain_level", 32'(level), 32'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    sync_data  = '0;
    sync_valid = 1'b0;
    out_ready  = 1'b0;
    p5_done    = 1'b0;
    rnd_stop   = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_retrieved", 32'(sync_retrieved), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ack_error", 32'(ack_error), 32'd0);
    @(posedge clk); #1;

    // Single word: capture at end of cycle 0, retrieved and visible in cycle 1
    out_ready  = 1'b1;
    sync_data  = 4'h1;
    sync_valid = 1'b1;
    sb.push_back(4'h1);
    words++;
    @(negedge clk);
    check("single_c0_retrieved", 32'(sync_retrieved), 32'd0);
    check("single_c0_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("single_c1_retrieved", 32'(sync_retrieved), 32'd1);
    check("single_c1_out_valid", 32'(out_valid), 32'd1);
    check("single_c1_out_data", 32'(out_data), 32'd1);
    check("single_c1_level", 32'(level), 32'd1);
    @(posedge clk); #1;
    sync_valid = 1'b0;
    @(negedge clk);
    check("single_c2_level", 32'(level), 32'd0);
    check("single_c2_retrieved", 32'(sync_retrieved), 32'd0);
    @(posedge clk); #1;

    // Burst fill: four words fill the FIFO, the fifth stays parked
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) present(W'(i), 50);
    check("burst_level_full", 32'(level), 32'd4);
    fork
      begin
        present(4'h5, 200);
        p5_done = 1'b1;
      end
    join_none
    repeat (6) @(posedge clk);
    #1;
    check("burst_held_level", 32'(level), 32'd4);
    check("burst_held_pulses", 32'(pulses), 32'(words - 1));
    out_ready = 1'b1;
    @(negedge clk);
    check("burst_pop_level", 32'(level), 32'd4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("burst_after_pop_level", 32'(level), 32'd3);
    check("burst_after_pop_retr", 32'(sync_retrieved), 32'd0);
    @(negedge clk);
    check("burst_w5_retrieved", 32'(sync_retrieved), 32'd1);
    check("burst_w5_level", 32'(level), 32'd4);
    for (int i = 0; i < 20 && !p5_done; i++) @(posedge clk);
    check("burst_w5_done", 32'(p5_done), 32'd1);
    @(posedge clk); #1;
    drain(20);

    // Simultaneous push and pop at level 2
    out_ready = 1'b0;
    present(4'h6, 50);
    present(4'h7, 50);
    check("simul_pre_level", 32'(level), 32'd2);
    sync_data  = 4'h8;
    sync_valid = 1'b1;
    sb.push_back(4'h8);
    words++;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("simul_level", 32'(level), 32'd2);
    check("simul_retrieved", 32'(sync_retrieved), 32'd1);
    check("simul_head", 32'(out_data), 32'd7);
    @(posedge clk); #1;
    sync_valid = 1'b0;
    @(posedge clk); #1;
    drain(20);

    // Wrap-around stream under random backpressure
    fork
      begin
        while (!rnd_stop) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 10; i++) present(W'(i), 200);
    rnd_stop = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    drain(40);
    @(posedge clk); #1;
    check("wrap_pulses", 32'(pulses), 32'(words));

    // Retrieve-handshake timeout with sync_valid stuck high
    out_ready  = 1'b1;
    sync_data  = 4'hA;
    sync_valid = 1'b1;
    sb.push_back(4'hA);
    words++;
    begin
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (sync_retrieved) begin
          got = 1;
          break;
        end
      end
      check("to_retrieved", 32'(got), 32'd1);
    end
    repeat (2) @(negedge clk);
    check("to_err_early", 32'(ack_error), 32'd0);
    repeat (10) @(negedge clk);
    check("to_err_set", 32'(ack_error), 32'd1);
    check("to_no_recapture", 32'(pulses), 32'(words));
    check("to_level", 32'(level), 32'd0);
    @(posedge clk); #1;
    sync_valid = 1'b0;
    @(posedge clk); #1;
    present(4'hB, 50);
    check("to_err_sticky", 32'(ack_error), 32'd1);
    check("to_next_pulses", 32'(pulses), 32'(words));
    drain(20);

    // Reset during ACK with three words stored
    out_ready = 1'b0;
    present(4'h1, 50);
    present(4'h2, 50);
    sync_data  = 4'h3;
    sync_valid = 1'b1;
    words++;
    begin
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (sync_retrieved) begin
          got = 1;
          break;
        end
      end
      check("rstop_retrieved", 32'(got), 32'd1);
    end
    check("rstop_level3", 32'(level), 32'd3);
    #1;
    reset_n    = 1'b0;
    sync_valid = 1'b0;
    @(negedge clk);
    check("rstop_retr", 32'(sync_retrieved), 32'd0);
    check("rstop_level", 32'(level), 32'd0);
    check("rstop_out_valid", 32'(out_valid), 32'd0);
    check("rstop_ack_error", 32'(ack_error), 32'd0);
    check("rstop_state", 32'(dut.state), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    present(4'hC, 50);
    drain(20);

    check("final_pulses", 32'(pulses), 32'(words));
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
